// File: rtl/sdram_burst_splitter_if.sv
// Request and command streams between a linear-address requester, the burst splitter and sdram_phy.
// The slave modport is the splitter's view; the master modport is the view of whatever drives it.
interface sdram_burst_splitter_if #(
    parameter int unsigned ADDR_W = 24
);
    logic [ADDR_W+16:0] s_axis_req_data;
    logic               s_axis_req_valid;
    logic               s_axis_req_ready;
    logic [39:0]        m_axis_usr_cmd_data;
    logic [16:0]        m_axis_usr_cmd_user;
    logic               m_axis_usr_cmd_valid;
    logic               m_axis_usr_cmd_ready;

    modport slave (
        input  s_axis_req_data,
        input  s_axis_req_valid,
        output s_axis_req_ready,
        output m_axis_usr_cmd_data,
        output m_axis_usr_cmd_user,
        output m_axis_usr_cmd_valid,
        input  m_axis_usr_cmd_ready
    );

    modport master (
        output s_axis_req_data,
        output s_axis_req_valid,
        input  s_axis_req_ready,
        input  m_axis_usr_cmd_data,
        input  m_axis_usr_cmd_user,
        input  m_axis_usr_cmd_valid,
        output m_axis_usr_cmd_ready
    );
endinterface

// File: rtl/sdram_burst_splitter.sv
// Splits linear word-address read/write requests into sdram_phy full-page burst commands that
// never cross a row boundary or a MAX_BURST_LEN-aligned column window.
module sdram_burst_splitter #(
    parameter int unsigned SDRAM_COL_N   = 512,
    parameter int unsigned SDRAM_ROW_N   = 8192,
    parameter int unsigned MAX_BURST_LEN = 512,
    parameter logic [2:0]  CMD_ID_WT     = 3'd1,
    parameter logic [2:0]  CMD_ID_RD     = 3'd2,
    parameter int unsigned SIM_DELAY     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    sdram_burst_splitter_if.slave  bus,
    output logic                   busy
);
    localparam int unsigned COL_W  = $clog2(SDRAM_COL_N);
    localparam int unsigned ROW_W  = $clog2(SDRAM_ROW_N);
    localparam int unsigned ADDR_W = 2 + ROW_W + COL_W;
    localparam int unsigned LEN_W  = 17;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SPLIT = 1'b1;

    // SIM_DELAY is kept so existing parameter maps for this block still elaborate.
    if (SIM_DELAY != 0) begin : g_sim_delay
    end

    logic [0:0]        state_q,     state_d;
    logic              req_ready_q, req_ready_d;
    logic              is_write_q,  is_write_d;
    logic [ADDR_W-1:0] cur_addr_q,  cur_addr_d;
    logic [LEN_W-1:0]  remain_q,    remain_d;
    logic [LEN_W-1:0]  seg_len_q,   seg_len_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [39:0]       cmd_data_q,  cmd_data_d;
    logic [16:0]       cmd_user_q,  cmd_user_d;

    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              req_fire;
    logic              cmd_fire;
    logic [ADDR_W-1:0] nxt_addr;
    logic [LEN_W-1:0]  nxt_remain;
    logic              last_seg;

    logic              src_load;
    logic              src_wr;
    logic [ADDR_W-1:0] src_addr;
    logic [LEN_W-1:0]  src_remain;

    logic [COL_W-1:0]  src_col;
    logic [ROW_W-1:0]  src_row;
    logic [1:0]        src_ba;
    logic [LEN_W-1:0]  lim_row;
    logic [LEN_W-1:0]  lim_win;
    logic [LEN_W-1:0]  src_seg;

    assign req_wr   = bus.s_axis_req_data[ADDR_W+16];
    assign req_addr = bus.s_axis_req_data[ADDR_W+15:16];
    assign req_len  = LEN_W'(bus.s_axis_req_data[15:0]) + LEN_W'(1);

    // Pick the segment to present next: a fresh request, or the continuation of the current one.
    always_comb begin
        req_fire   = bus.s_axis_req_valid && req_ready_q;
        cmd_fire   = cmd_valid_q && bus.m_axis_usr_cmd_ready;
        nxt_addr   = cur_addr_q + ADDR_W'(seg_len_q);
        nxt_remain = remain_q - seg_len_q;
        last_seg   = (nxt_remain == LEN_W'(0));
        src_load   = 1'b0;
        src_wr     = req_wr;
        src_addr   = req_addr;
        src_remain = req_len;
        if (state_q == ST_IDLE) begin
            src_load = req_fire;
        end else begin
            src_wr     = is_write_q;
            src_addr   = nxt_addr;
            src_remain = nxt_remain;
            src_load   = cmd_fire && !last_seg;
        end
    end

    // Segment length: clipped to remaining words, end of row and end of the burst window.
    always_comb begin
        src_col = src_addr[COL_W-1:0];
        src_row = src_addr[COL_W +: ROW_W];
        src_ba  = src_addr[ADDR_W-1 -: 2];
        lim_row = LEN_W'(SDRAM_COL_N) - LEN_W'(src_col);
        lim_win = LEN_W'(MAX_BURST_LEN) - LEN_W'(src_col & COL_W'(MAX_BURST_LEN - 1));
        src_seg = src_remain;
        if (lim_row < src_seg) begin
            src_seg = lim_row;
        end
        if (lim_win < src_seg) begin
            src_seg = lim_win;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        is_write_d  = is_write_q;
        cur_addr_d  = cur_addr_q;
        remain_d    = remain_q;
        seg_len_d   = seg_len_q;
        cmd_valid_d = cmd_valid_q;
        cmd_data_d  = cmd_data_q;
        cmd_user_d  = cmd_user_q;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_fire) begin
                    req_ready_d = 1'b0;
                    is_write_d  = req_wr;
                    state_d     = ST_SPLIT;
                end
            end
            ST_SPLIT: begin
                if (cmd_fire && last_seg) begin
                    cmd_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_valid_d = 1'b0;
                req_ready_d = 1'b0;
            end
        endcase

        if (src_load) begin
            cur_addr_d  = src_addr;
            remain_d    = src_remain;
            seg_len_d   = src_seg;
            cmd_valid_d = 1'b1;
            cmd_data_d  = {3'b000, src_ba, 16'(src_row), 16'(src_col),
                           src_wr ? CMD_ID_WT : CMD_ID_RD};
            cmd_user_d  = {1'b1, 16'(src_seg - LEN_W'(1))};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            is_write_q  <= 1'b0;
            cur_addr_q  <= '0;
            remain_q    <= '0;
            seg_len_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
            cmd_user_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            is_write_q  <= is_write_d;
            cur_addr_q  <= cur_addr_d;
            remain_q    <= remain_d;
            seg_len_q   <= seg_len_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            cmd_user_q  <= cmd_user_d;
        end
    end

    assign bus.s_axis_req_ready     = req_ready_q;
    assign bus.m_axis_usr_cmd_valid = cmd_valid_q;
    assign bus.m_axis_usr_cmd_data  = cmd_data_q;
    assign bus.m_axis_usr_cmd_user  = cmd_user_q;
    assign busy                     = (state_q == ST_SPLIT);

endmodule

// File: tb/tb_sdram_burst_splitter.sv
// Bench for sdram_burst_splitter: two instances (MAX_BURST_LEN 512 and 128), scoreboard of expected commands.
module tb_sdram_burst_splitter;
    localparam int unsigned AW = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [56:0] sb_a[$];
    logic [56:0] sb_b[$];

    logic rdy_mode;
    logic rdy_val;
    logic rnd_a;
    logic rnd_b;
    logic busy_a;
    logic busy_b;

    sdram_burst_splitter_if #(.ADDR_W(AW)) if_a ();
    sdram_burst_splitter_if #(.ADDR_W(AW)) if_b ();

    assign if_a.m_axis_usr_cmd_ready = rdy_mode ? rnd_a : rdy_val;
    assign if_b.m_axis_usr_cmd_ready = rdy_mode ? rnd_b : rdy_val;

    sdram_burst_splitter #(.SDRAM_COL_N(512), .SDRAM_ROW_N(8192), .MAX_BURST_LEN(512)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a.slave), .busy(busy_a));

    sdram_burst_splitter #(.SDRAM_COL_N(512), .SDRAM_ROW_N(8192), .MAX_BURST_LEN(128)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave), .busy(busy_b));

    function automatic logic [AW-1:0] ad(input int ba, input int row, input int col);
        return {2'(ba), 13'(row), 9'(col)};
    endfunction

    function automatic logic [56:0] mk(input bit wr, input logic [AW-1:0] a, input int n);
        logic [39:0] d;
        logic [16:0] u;
        d = {3'b000, a[23:22], 3'b000, a[21:9], 7'b0, a[8:0], wr ? 3'd1 : 3'd2};
        u = {1'b1, 16'(n - 1)};
        return {d, u};
    endfunction

    // Word-by-word reference: a segment closes when the next word starts a new burst window.
    task automatic model_push(input bit sel, input bit wr, input logic [AW-1:0] addr,
                              input logic [15:0] lenm1, input int mbl);
        int remain;
        int n;
        logic [AW-1:0] a;
        logic [AW-1:0] start;
        remain = int'(lenm1) + 1;
        a = addr;
        while (remain > 0) begin
            start = a;
            n = 0;
            do begin
                a = a + 24'd1;
                n++;
                remain--;
            end while (remain > 0 && (int'(a[8:0]) % mbl) != 0);
            if (sel) sb_b.push_back(mk(wr, start, n));
            else     sb_a.push_back(mk(wr, start, n));
        end
    endtask

    task automatic send_req(input bit sel, input bit wr, input logic [AW-1:0] addr,
                            input logic [15:0] lenm1, output int waited);
        int t;
        t = 0;
        @(posedge clk); #1;
        if (sel) begin
            if_b.s_axis_req_valid = 1'b1;
            if_b.s_axis_req_data  = {wr, addr, lenm1};
        end else begin
            if_a.s_axis_req_valid = 1'b1;
            if_a.s_axis_req_data  = {wr, addr, lenm1};
        end
        while ((sel ? if_b.s_axis_req_ready : if_a.s_axis_req_ready) !== 1'b1 && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (t >= 3000) begin
            errors++;
            $display("FAIL req_accept_timeout sel=%0d waited=%0d required<3000", sel, t);
        end
        @(posedge clk); #1;
        if_a.s_axis_req_valid = 1'b0;
        if_b.s_axis_req_valid = 1'b0;
        waited = t;
    endtask

    task automatic wait_drain(input bit sel, input int budget, input string name);
        int t;
        int bubbles;
        t = 0;
        bubbles = 0;
        while ((sel ? sb_b.size() : sb_a.size()) > 0 && t < budget) begin
            @(negedge clk); #1;
            if ((sel ? sb_b.size() : sb_a.size()) > 0 &&
                (sel ? if_b.m_axis_usr_cmd_valid : if_a.m_axis_usr_cmd_valid) !== 1'b1)
                bubbles++;
            t++;
        end
        checks++;
        if (t >= budget) begin
            errors++;
            $display("FAIL %s_drain_timeout left=%0d required=0", name, sel ? sb_b.size() : sb_a.size());
        end
        checks++;
        if (bubbles != 0) begin
            errors++;
            $display("FAIL %s_valid_bubbles got=%0d required=0", name, bubbles);
        end
        @(posedge clk); #1;
        checks++;
        if (sel ? ({if_b.m_axis_usr_cmd_valid, if_b.s_axis_req_ready, busy_b} !== 3'b010)
                : ({if_a.m_axis_usr_cmd_valid, if_a.s_axis_req_ready, busy_a} !== 3'b010)) begin
            errors++;
            $display("FAIL %s_idle_after got valid/ready/busy=%b%b%b required=010", name,
                     sel ? if_b.m_axis_usr_cmd_valid : if_a.m_axis_usr_cmd_valid,
                     sel ? if_b.s_axis_req_ready : if_a.s_axis_req_ready, sel ? busy_b : busy_a);
        end
    endtask

    // Scoreboard monitors: every presented command must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && if_a.m_axis_usr_cmd_valid === 1'b1) begin
                checks++;
                if (sb_a.size() == 0) begin
                    errors++;
                    $display("FAIL mon_a_unexpected got=%h required=none",
                             {if_a.m_axis_usr_cmd_data, if_a.m_axis_usr_cmd_user});
                end else if ({if_a.m_axis_usr_cmd_data, if_a.m_axis_usr_cmd_user} !== sb_a[0]) begin
                    errors++;
                    $display("FAIL mon_a_cmd got=%h required=%h",
                             {if_a.m_axis_usr_cmd_data, if_a.m_axis_usr_cmd_user}, sb_a[0]);
                end
                if (if_a.m_axis_usr_cmd_ready === 1'b1 && sb_a.size() > 0) void'(sb_a.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && if_b.m_axis_usr_cmd_valid === 1'b1) begin
                checks++;
                if (sb_b.size() == 0) begin
                    errors++;
                    $display("FAIL mon_b_unexpected got=%h required=none",
                             {if_b.m_axis_usr_cmd_data, if_b.m_axis_usr_cmd_user});
                end else if ({if_b.m_axis_usr_cmd_data, if_b.m_axis_usr_cmd_user} !== sb_b[0]) begin
                    errors++;
                    $display("FAIL mon_b_cmd got=%h required=%h",
                             {if_b.m_axis_usr_cmd_data, if_b.m_axis_usr_cmd_user}, sb_b[0]);
                end
                if (if_b.m_axis_usr_cmd_ready === 1'b1 && sb_b.size() > 0) void'(sb_b.pop_front());
            end
        end
    end

    initial begin
        rnd_a = 1'b1;
        rnd_b = 1'b1;
        forever begin
            @(posedge clk); #1;
            rnd_a = 1'($urandom_range(0, 1));
            rnd_b = 1'($urandom_range(0, 1));
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({if_a.s_axis_req_ready, if_a.m_axis_usr_cmd_valid, busy_a, if_b.s_axis_req_ready} !== 4'b0000 ||
            if_a.m_axis_usr_cmd_data !== 40'd0 || if_a.m_axis_usr_cmd_user !== 17'd0) begin
            errors++;
            $display("FAIL reset_values got rdy/vld/busy=%b%b%b data=%h user=%h required=000 0 0",
                     if_a.s_axis_req_ready, if_a.m_axis_usr_cmd_valid, busy_a,
                     if_a.m_axis_usr_cmd_data, if_a.m_axis_usr_cmd_user);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (if_a.s_axis_req_ready !== 1'b1 || if_b.s_axis_req_ready !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready got a=%b b=%b busy=%b required=1 1 0",
                     if_a.s_axis_req_ready, if_b.s_axis_req_ready, busy_a);
        end
    endtask

    task automatic test_single_write();
        int w;
        sb_a.push_back(mk(1'b1, ad(0, 5, 0), 512));
        send_req(1'b0, 1'b1, ad(0, 5, 0), 16'd511, w);
        checks++;
        if ({if_a.m_axis_usr_cmd_valid, if_a.s_axis_req_ready, busy_a} !== 3'b101) begin
            errors++;
            $display("FAIL single_latency got valid/ready/busy=%b%b%b required=101",
                     if_a.m_axis_usr_cmd_valid, if_a.s_axis_req_ready, busy_a);
        end
        @(posedge clk); #1;
        checks++;
        if ({if_a.m_axis_usr_cmd_valid, if_a.s_axis_req_ready, busy_a} !== 3'b010 || sb_a.size() != 0) begin
            errors++;
            $display("FAIL single_ready_back got valid/ready/busy=%b%b%b left=%0d required=010 left=0",
                     if_a.m_axis_usr_cmd_valid, if_a.s_axis_req_ready, busy_a, sb_a.size());
        end
    endtask

    task automatic test_row_cross();
        int w;
        sb_a.push_back(mk(1'b0, ad(0, 5, 500), 12));
        sb_a.push_back(mk(1'b0, ad(0, 6, 0), 8));
        send_req(1'b0, 1'b0, ad(0, 5, 500), 16'd19, w);
        wait_drain(1'b0, 50, "row_cross");
    endtask

    task automatic test_bank_carry();
        int w;
        sb_a.push_back(mk(1'b1, ad(0, 8191, 510), 2));
        sb_a.push_back(mk(1'b1, ad(1, 0, 0), 2));
        send_req(1'b0, 1'b1, ad(0, 8191, 510), 16'd3, w);
        wait_drain(1'b0, 50, "bank_carry");
    endtask

    task automatic test_full_wrap();
        int w;
        sb_a.push_back(mk(1'b0, ad(3, 8191, 511), 1));
        sb_a.push_back(mk(1'b0, ad(0, 0, 0), 1));
        send_req(1'b0, 1'b0, ad(3, 8191, 511), 16'd1, w);
        wait_drain(1'b0, 50, "full_wrap");
    endtask

    task automatic test_mbl128();
        int w;
        sb_b.push_back(mk(1'b1, ad(0, 2, 100), 28));
        sb_b.push_back(mk(1'b1, ad(0, 2, 128), 128));
        sb_b.push_back(mk(1'b1, ad(0, 2, 256), 128));
        sb_b.push_back(mk(1'b1, ad(0, 2, 384), 16));
        send_req(1'b1, 1'b1, ad(0, 2, 100), 16'd299, w);
        wait_drain(1'b1, 50, "mbl128");
    endtask

    task automatic test_back_to_back();
        int w;
        sb_a.push_back(mk(1'b1, ad(2, 100, 0), 512));
        sb_a.push_back(mk(1'b1, ad(2, 101, 0), 512));
        sb_a.push_back(mk(1'b0, ad(1, 7, 256), 256));
        send_req(1'b0, 1'b1, ad(2, 100, 0), 16'd1023, w);
        send_req(1'b0, 1'b0, ad(1, 7, 256), 16'd255, w);
        checks++;
        if (w != 1) begin
            errors++;
            $display("FAIL b2b_ready_gap got=%0d required=1", w);
        end
        wait_drain(1'b0, 50, "b2b");
    endtask

    task automatic test_max_len();
        int w;
        model_push(1'b0, 1'b1, ad(2, 0, 0), 16'hFFFF, 512);
        send_req(1'b0, 1'b1, ad(2, 0, 0), 16'hFFFF, w);
        wait_drain(1'b0, 400, "max_len_a");
        model_push(1'b1, 1'b0, ad(1, 8191, 5), 16'hFFFF, 128);
        send_req(1'b1, 1'b0, ad(1, 8191, 5), 16'hFFFF, w);
        wait_drain(1'b1, 1000, "max_len_b");
    endtask

    task automatic test_stall_and_reset();
        int w;
        rdy_val = 1'b0;
        sb_a.push_back(mk(1'b0, ad(1, 10, 0), 512));
        sb_a.push_back(mk(1'b0, ad(1, 11, 0), 512));
        sb_a.push_back(mk(1'b0, ad(1, 12, 0), 512));
        send_req(1'b0, 1'b0, ad(1, 10, 0), 16'd1535, w);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            checks++;
            if (if_a.m_axis_usr_cmd_valid !== 1'b1 ||
                {if_a.m_axis_usr_cmd_data, if_a.m_axis_usr_cmd_user} !== sb_a[0]) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got valid=%b cmd=%h required=1 %h", i,
                         if_a.m_axis_usr_cmd_valid, {if_a.m_axis_usr_cmd_data, if_a.m_axis_usr_cmd_user}, sb_a[0]);
            end
        end
        @(posedge clk); #1;
        rdy_val = 1'b1;
        @(posedge clk); #1;
        rdy_val = 1'b0;
        checks++;
        if (sb_a.size() != 2 || if_a.m_axis_usr_cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_one_accept got left=%0d valid=%b required=2 1", sb_a.size(),
                     if_a.m_axis_usr_cmd_valid);
        end
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({if_a.m_axis_usr_cmd_valid, if_a.s_axis_req_ready, busy_a} !== 3'b000 ||
            if_a.m_axis_usr_cmd_data !== 40'd0 || if_a.m_axis_usr_cmd_user !== 17'd0) begin
            errors++;
            $display("FAIL midsplit_reset got valid/ready/busy=%b%b%b data=%h user=%h required=000 0 0",
                     if_a.m_axis_usr_cmd_valid, if_a.s_axis_req_ready, busy_a,
                     if_a.m_axis_usr_cmd_data, if_a.m_axis_usr_cmd_user);
        end
        sb_a.delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rdy_val = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({if_a.m_axis_usr_cmd_valid, if_a.s_axis_req_ready, busy_a} !== 3'b010) begin
            errors++;
            $display("FAIL reset_release_idle got valid/ready/busy=%b%b%b required=010",
                     if_a.m_axis_usr_cmd_valid, if_a.s_axis_req_ready, busy_a);
        end
        sb_a.push_back(mk(1'b1, ad(0, 1, 3), 1));
        send_req(1'b0, 1'b1, ad(0, 1, 3), 16'd0, w);
        wait_drain(1'b0, 20, "post_reset");
    endtask

    task automatic test_random();
        int w;
        logic [AW-1:0] a;
        logic [15:0] l;
        bit wr;
        rdy_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a  = AW'($urandom);
            l  = 16'($urandom_range(0, 1500));
            wr = 1'($urandom_range(0, 1));
            model_push(i[0], wr, a, l, i[0] ? 128 : 512);
            send_req(i[0], wr, a, l, w);
            wait_drain(i[0], 2000, "random");
        end
        rdy_mode = 1'b0;
        rdy_val  = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        rdy_mode = 1'b0;
        rdy_val  = 1'b1;
        if_a.s_axis_req_valid = 1'b0;
        if_a.s_axis_req_data  = '0;
        if_b.s_axis_req_valid = 1'b0;
        if_b.s_axis_req_data  = '0;
        test_reset();
        test_single_write();
        test_row_cross();
        test_bank_carry();
        test_full_wrap();
        test_mbl128();
        test_back_to_back();
        test_max_len();
        test_stall_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
